// File: rtl/tl_cntr_param.sv
// tl_cntr_param -- two-road traffic-light controller with programmable timing
// and a latched pedestrian request served by an all-red WALK phase.
//
// Ports:
//   clk      in   rising-edge system clock
//   reset_n  in   synchronous active-low reset
//   Ta, Tb   in   traffic present on road A / road B
//   ped_req  in   pedestrian button (pulse or level), sampled every cycle
//   La, Lb   out  lamp codes: 00 green, 01 yellow, 10 red
//   walk     out  pedestrian WALK lamp
//   phase    out  current state code (debug)
module tl_cntr_param #(
    parameter int CW   = 8,
    parameter int GMIN = 4,
    parameter int GMAX = 10,
    parameter int YEL  = 2,
    parameter int CLR  = 1,
    parameter int WALK = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       ped_req,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_AG   = 3'd0,
        S_AY   = 3'd1,
        S_ACLR = 3'd2,
        S_BG   = 3'd3,
        S_BY   = 3'd4,
        S_BCLR = 3'd5,
        S_PED  = 3'd6
    } state_t;

    localparam logic [1:0] LGRN = 2'b00;
    localparam logic [1:0] LYEL = 2'b01;
    localparam logic [1:0] LRED = 2'b10;

    localparam logic [CW-1:0] GMIN_M1 = CW'(GMIN - 1);
    localparam logic [CW-1:0] GMAX_M1 = CW'(GMAX - 1);
    localparam logic [CW-1:0] YEL_M1  = CW'(YEL - 1);
    localparam logic [CW-1:0] CLR_M1  = CW'(CLR - 1);
    localparam logic [CW-1:0] WALK_M1 = CW'(WALK - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          ped_pend;
    logic          ped_any;
    // 1: the walk phase hands over to road B green, 0: to road A green
    logic          next_road, next_road_nxt;

    // a press in the very cycle the clearance ends still earns the walk
    assign ped_any = ped_pend | ped_req;

    always_comb begin
        state_nxt     = state;
        next_road_nxt = next_road;
        case (state)
            S_AG:   if ((cnt >= GMIN_M1 && !Ta) || cnt == GMAX_M1) state_nxt = S_AY;
            S_AY:   if (cnt == YEL_M1) state_nxt = S_ACLR;
            S_ACLR: if (cnt == CLR_M1) begin
                        if (ped_any) begin
                            state_nxt     = S_PED;
                            next_road_nxt = 1'b1;
                        end else begin
                            state_nxt     = S_BG;
                        end
                    end
            S_BG:   if ((cnt >= GMIN_M1 && !Tb) || cnt == GMAX_M1) state_nxt = S_BY;
            S_BY:   if (cnt == YEL_M1) state_nxt = S_BCLR;
            S_BCLR: if (cnt == CLR_M1) begin
                        if (ped_any) begin
                            state_nxt     = S_PED;
                            next_road_nxt = 1'b0;
                        end else begin
                            state_nxt     = S_AG;
                        end
                    end
            S_PED:  if (cnt == WALK_M1) state_nxt = next_road ? S_BG : S_AG;
            default: state_nxt = S_AG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_AG;
            cnt       <= '0;
            ped_pend  <= 1'b0;
            next_road <= 1'b0;
        end else begin
            state     <= state_nxt;
            next_road <= next_road_nxt;
            cnt       <= (state_nxt != state) ? '0 : cnt + 1'b1;
            // entering the walk consumes the pending request; a press on the
            // same edge re-arms it for the next clearance
            if (state_nxt == S_PED && state != S_PED)
                ped_pend <= ped_req;
            else
                ped_pend <= ped_any;
        end
    end

    always_comb begin
        La   = LRED;
        Lb   = LRED;
        walk = 1'b0;
        case (state)
            S_AG:  La   = LGRN;
            S_AY:  La   = LYEL;
            S_BG:  Lb   = LGRN;
            S_BY:  Lb   = LYEL;
            S_PED: walk = 1'b1;
            default: ;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_tl_cntr_param.sv
// Directed bench for tl_cntr_param at default parameters. Phase sequences and
// lamp codes are hand-derived; invariants are checked every cycle after reset.
module tb_tl_cntr_param;

    localparam int AG = 0, AY = 1, ACLR = 2, BG = 3, BY = 4, BCLR = 5, PED = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       Ta = 1'b0, Tb = 1'b0, ped_req = 1'b0;
    logic [1:0] La, Lb;
    logic       walk;
    logic [2:0] phase;

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;

    tl_cntr_param dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Ta      (Ta),
        .Tb      (Tb),
        .ped_req (ped_req),
        .La      (La),
        .Lb      (Lb),
        .walk    (walk),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_la(input int p);
        case (p)
            AG:      return 0;
            AY:      return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int exp_lb(input int p);
        case (p)
            BG:      return 0;
            BY:      return 1;
            default: return 2;
        endcase
    endfunction

    // n consecutive cycles expected in phase p, sampled mid-cycle
    task automatic run(input string tag, input int p, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, ".phase"}, int'(phase), p);
            chk({tag, ".La"}, int'(La), exp_la(p));
            chk({tag, ".Lb"}, int'(Lb), exp_lb(p));
            chk({tag, ".walk"}, int'(walk), (p == PED) ? 1 : 0);
        end
    endtask

    // two reset edges with junk inputs, then release with the given sensors
    task automatic do_reset(input logic ta, input logic tb);
        reset_n = 1'b0;
        Ta = 1'b1; Tb = 1'b1; ped_req = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.phase", int'(phase), AG);
        chk("rst.La", int'(La), 0);
        chk("rst.Lb", int'(Lb), 2);
        chk("rst.walk", int'(walk), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        Ta = ta; Tb = tb; ped_req = 1'b0;
        armed = 1'b1;
    endtask

    // single-cycle ped press sampled at the edge ending the first AG cycle
    task automatic ag_with_pulse(input string tag);
        ped_req = 1'b1;
        run(tag, AG, 1);
        @(posedge clk);
        #1;
        ped_req = 1'b0;
        run(tag, AG, 3);
    endtask

    always @(negedge clk) begin
        if (armed && reset_n) begin
            chk("inv.nogg", int'(La == 2'b00 && Lb == 2'b00), 0);
            chk("inv.walk", int'(walk && !(La == 2'b10 && Lb == 2'b10)), 0);
            chk("inv.ph7", int'(phase == 3'd7), 0);
        end
    end

    initial begin
        // road A busy: A holds to GMAX, B has no traffic so leaves at GMIN
        do_reset(1'b1, 1'b0);
        run("t2", AG, 10); run("t2", AY, 2); run("t2", ACLR, 1);
        run("t2", BG, 4);  run("t2", BY, 2); run("t2", BCLR, 1);
        run("t2", AG, 2);

        // road B busy: A leaves at GMIN, B holds to GMAX
        do_reset(1'b0, 1'b1);
        run("t3", AG, 4); run("t3", AY, 2); run("t3", ACLR, 1);
        run("t3", BG, 10); run("t3", BY, 1);

        // one press -> one walk, then normal alternation
        do_reset(1'b0, 1'b0);
        ag_with_pulse("t4");
        run("t4", AY, 2); run("t4", ACLR, 1); run("t4", PED, 3);
        run("t4", BG, 4); run("t4", BY, 2);   run("t4", BCLR, 1);
        run("t4", AG, 2);

        // press held through the walk re-arms it for the next clearance
        do_reset(1'b0, 1'b0);
        ped_req = 1'b1;
        run("t5", AG, 4); run("t5", AY, 2); run("t5", ACLR, 1);
        run("t5", PED, 3); run("t5", BG, 4); run("t5", BY, 2);
        run("t5", BCLR, 1); run("t5", PED, 3); run("t5", AG, 1);
        ped_req = 1'b0;

        // reset during yellow drops the pending request
        do_reset(1'b0, 1'b0);
        ag_with_pulse("t6a");
        run("t6a", AY, 1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run("t6a", AG, 4); run("t6a", AY, 2); run("t6a", ACLR, 1);
        run("t6a", BG, 1);

        // reset during walk, with a fresh press latched in the walk
        do_reset(1'b0, 1'b0);
        ag_with_pulse("t6b");
        run("t6b", AY, 2); run("t6b", ACLR, 1);
        ped_req = 1'b1;
        run("t6b", PED, 1);
        run("t6b", PED, 1);
        ped_req = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run("t6b", AG, 4); run("t6b", AY, 2); run("t6b", ACLR, 1);
        run("t6b", BG, 1);

        armed = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
